// File: rtl/fp_result_normalizer_pkg.sv
// Shared constants and enumerations for the FP result post-normaliser.
package fp_result_normalizer_pkg;

   localparam int EXP_BITS  = 8;
   localparam int FRAC_BITS = 23;
   localparam int SIG_BITS  = FRAC_BITS + 2;

   localparam logic [EXP_BITS-1:0]  EXP_MAX   = 8'hFF;
   localparam logic [FRAC_BITS-1:0] QNAN_FRAC = 23'h400000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ACT_ZERO  = 3'd0,
      ACT_CARRY = 3'd1,
      ACT_PACK  = 3'd2,
      ACT_FLUSH = 3'd3,
      ACT_LEFT  = 3'd4
   } action_t;

endpackage

// File: rtl/fp_result_normalizer_norm_step.sv
// One normalisation step: picks the highest-priority action for the current
// exponent/significand and produces the shifted values that action implies.
import fp_result_normalizer_pkg::*;

module fp_norm_step (
   input  logic [EXP_BITS-1:0] exp_cur,
   input  logic [SIG_BITS-1:0] sig_cur,
   output logic [EXP_BITS-1:0] exp_next,
   output logic [SIG_BITS-1:0] sig_next,
   output action_t             action
);

   // Priority: zero, carry, already normalised, underflow, then shift left.
   always_comb begin
      exp_next = exp_cur;
      sig_next = sig_cur;
      action   = ACT_LEFT;
      if (sig_cur == '0) begin
         action = ACT_ZERO;
      end else if (sig_cur[SIG_BITS-1]) begin
         action   = ACT_CARRY;
         sig_next = {1'b0, sig_cur[SIG_BITS-1:1]};
         exp_next = exp_cur + 8'd1;
      end else if (sig_cur[SIG_BITS-2]) begin
         action = ACT_PACK;
      end else if (exp_cur <= 8'd1) begin
         action = ACT_FLUSH;
      end else begin
         action   = ACT_LEFT;
         sig_next = {sig_cur[SIG_BITS-2:0], 1'b0};
         exp_next = exp_cur - 8'd1;
      end
   end

endmodule

// File: rtl/fp_result_normalizer.sv
// Multi-cycle post-normaliser: shifts a raw ALU result one bit per cycle and
// packs an IEEE-754 single with overflow/underflow/zero flags.
import fp_result_normalizer_pkg::*;

module fp_result_normalizer #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [EXP_W-1:0]    in_exp,
   input  logic [FRAC_W+1:0]   in_sig,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [EXP_W+FRAC_W:0] out_result,
   output logic                out_ovf,
   output logic                out_unf,
   output logic                out_zero,
   output logic [4:0]          out_steps
);

   state_t                     state_q, state_d;
   logic                       sign_q, sign_d;
   logic [EXP_W-1:0]           exp_q, exp_d;
   logic [FRAC_W+1:0]          sig_q, sig_d;
   logic [4:0]                 steps_q, steps_d;
   logic [EXP_W+FRAC_W:0]      result_q, result_d;
   logic                       ovf_q, ovf_d;
   logic                       unf_q, unf_d;
   logic                       zero_q, zero_d;

   logic [EXP_W-1:0]           step_exp;
   logic [FRAC_W+1:0]          step_sig;
   action_t                    step_action;

   fp_norm_step u_step (
      .exp_cur  (exp_q),
      .sig_cur  (sig_q),
      .exp_next (step_exp),
      .sig_next (step_sig),
      .action   (step_action)
   );

   assign in_ready   = (state_q == ST_IDLE) & rst_n;
   assign out_valid  = (state_q == ST_DONE);
   assign out_result = result_q;
   assign out_ovf    = ovf_q;
   assign out_unf    = unf_q;
   assign out_zero   = zero_q;
   assign out_steps  = steps_q;

   // Next-state and datapath update; DONE holds everything until the consumer takes it.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      exp_d    = exp_q;
      sig_d    = sig_q;
      steps_d  = steps_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      zero_d   = zero_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               sign_d   = in_sign;
               exp_d    = in_exp;
               sig_d    = in_sig;
               steps_d  = 5'd0;
               result_d = '0;
               ovf_d    = 1'b0;
               unf_d    = 1'b0;
               zero_d   = 1'b0;
               state_d  = ST_SHIFT;
               if (in_exp == EXP_MAX) begin
                  state_d = ST_DONE;
                  if (in_sig[FRAC_W-1:0] == '0) begin
                     result_d = {in_sign, EXP_MAX, {FRAC_W{1'b0}}};
                     ovf_d    = 1'b1;
                  end else begin
                     result_d = {in_sign, EXP_MAX, QNAN_FRAC};
                  end
               end
            end
         end
         ST_SHIFT: begin
            unique case (step_action)
               ACT_ZERO: begin
                  result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                  zero_d   = 1'b1;
                  state_d  = ST_DONE;
               end
               ACT_CARRY: begin
                  exp_d   = step_exp;
                  sig_d   = step_sig;
                  steps_d = steps_q + 5'd1;
                  if (step_exp == EXP_MAX) begin
                     result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                     ovf_d    = 1'b1;
                     state_d  = ST_DONE;
                  end
               end
               ACT_PACK: begin
                  result_d = {sign_q, exp_q, sig_q[FRAC_W-1:0]};
                  state_d  = ST_DONE;
               end
               ACT_FLUSH: begin
                  result_d = {sign_q, {(EXP_W+FRAC_W){1'b0}}};
                  unf_d    = 1'b1;
                  zero_d   = 1'b1;
                  state_d  = ST_DONE;
               end
               default: begin
                  exp_d   = step_exp;
                  sig_d   = step_sig;
                  steps_d = steps_q + 5'd1;
               end
            endcase
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         sig_q    <= '0;
         steps_q  <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         sig_q    <= sig_d;
         steps_q  <= steps_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_fp_result_normalizer.sv
// Scoreboard bench for fp_result_normalizer: directed vectors with hand-computed
// results, a decoupled monitor, stall and mid-transaction reset checks.
module tb_fp_result_normalizer;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [24:0] sig;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        zero;
      logic [4:0]  steps;
      int          lat;
      int          acc_cyc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign = 1'b0;
   logic [7:0]  in_exp = '0;
   logic [24:0] in_sig = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_ovf;
   logic        out_unf;
   logic        out_zero;
   logic [4:0]  out_steps;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   rise_cyc = 0;
   logic prev_valid = 1'b0;
   vec_t sb[$];
   vec_t vecs[$];

   fp_result_normalizer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_sig     (in_sig),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf),
      .out_zero   (out_zero),
      .out_steps  (out_steps)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      $display("[TB] FAIL %s: timed out waiting for the DUT", name);
   endtask

   function automatic vec_t mk(input logic sign, input logic [7:0] exp, input logic [24:0] sig,
                               input logic [31:0] res, input logic ovf, input logic unf,
                               input logic zero, input logic [4:0] steps, input int lat);
      vec_t v;
      v.sign = sign; v.exp = exp; v.sig = sig; v.res = res;
      v.ovf = ovf; v.unf = unf; v.zero = zero; v.steps = steps;
      v.lat = lat; v.acc_cyc = 0;
      return v;
   endfunction

   task automatic apply_stimulus(input vec_t v);
      int budget = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_sign  = v.sign;
      in_exp   = v.exp;
      in_sig   = v.sig;
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         fail_timeout("accept");
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      v.acc_cyc = cyc;
      sb.push_back(v);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int budget = 0;
      while (sb.size() > 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (sb.size() > 0) fail_timeout("drain");
   endtask

   task automatic wait_valid();
      int budget = 0;
      while (!out_valid && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (!out_valid) fail_timeout("out_valid");
   endtask

   // Monitor: latency is counted from the cycle after the accept edge (cycle 1).
   always @(negedge clk) begin
      vec_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid && !prev_valid) rise_cyc = cyc;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL unexpected_output: got %0h, expected no output", out_result);
            end else begin
               e = sb.pop_front();
               check_output("result", out_result, e.res);
               check_output("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
               check_output("unf", {31'd0, out_unf}, {31'd0, e.unf});
               check_output("zero", {31'd0, out_zero}, {31'd0, e.zero});
               check_output("steps", {27'd0, out_steps}, {27'd0, e.steps});
               check_output("latency", 32'(rise_cyc - e.acc_cyc + 1), 32'(e.lat));
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t t3;
      vecs.push_back(mk(1'b0, 8'h7F, 25'h0800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 5'd0, 2));
      vecs.push_back(mk(1'b0, 8'h80, 25'h1000000, 32'h40800000, 1'b0, 1'b0, 1'b0, 5'd1, 3));
      vecs.push_back(mk(1'b0, 8'h85, 25'h0000100, 32'h3B000000, 1'b0, 1'b0, 1'b0, 5'd15, 17));
      vecs.push_back(mk(1'b0, 8'hFE, 25'h1800000, 32'h7F800000, 1'b1, 1'b0, 1'b0, 5'd1, 2));
      vecs.push_back(mk(1'b0, 8'hFF, 25'h0000005, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 5'd0, 1));
      vecs.push_back(mk(1'b1, 8'hFF, 25'h0800000, 32'hFF800000, 1'b1, 1'b0, 1'b0, 5'd0, 1));
      vecs.push_back(mk(1'b1, 8'h02, 25'h0000001, 32'h80000000, 1'b0, 1'b1, 1'b1, 5'd1, 3));
      vecs.push_back(mk(1'b0, 8'h10, 25'h0000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 5'd0, 2));
      vecs.push_back(mk(1'b0, 8'h40, 25'h0000001, 32'h14800000, 1'b0, 1'b0, 1'b0, 5'd23, 25));
      vecs.push_back(mk(1'b0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 1'b0, 1'b0, 1'b0, 5'd1, 3));
      vecs.push_back(mk(1'b1, 8'h81, 25'h0400000, 32'hC0000000, 1'b0, 1'b0, 1'b0, 5'd1, 3));

      // Reset state
      #12;
      check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("rst_result", out_result, 32'd0);
      check_output("rst_flags", {29'd0, out_ovf, out_unf, out_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("idle_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;

      foreach (vecs[i]) apply_stimulus(vecs[i]);
      wait_drain();

      // Consumer stall: DONE must hold with outputs unchanged
      out_ready = 1'b0;
      apply_stimulus(vecs[0]);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("stall_valid", {31'd0, out_valid}, 32'd1);
         check_output("stall_result", out_result, 32'h3F800000);
         check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      wait_drain();

      // Asynchronous reset while a result is waiting in DONE
      out_ready = 1'b0;
      t3 = vecs[2];
      apply_stimulus(t3);
      wait_valid();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check_output("abort_result", out_result, 32'd0);
      check_output("abort_in_ready", {31'd0, in_ready}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("release_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      apply_stimulus(vecs[1]);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
